rx_huge_pages_ring: RTL
=======================

Name: rx_huge_pages_ring

Overview:
- Parametrised successor of the two-slot RX huge-page address register block.
- Holds NUM_PAGES host huge-page base addresses that the driver posts by memory writes into BAR0 on the TRN RX local-link.
- Presents them in strict ring order to the packet-to-hugepage writer, which releases each page with a one-cycle done pulse.
- Accepts 3DW and 4DW headers, honours discontinue, and flags host overrun of a still-owned slot.

Parameters:
- NUM_PAGES, 4, number of ring slots; power of two, 2..16.
- IDX_W, 2, log2(NUM_PAGES).
- BASE_OFFSET, 12'h040, BAR0 byte offset of slot 0; slot k sits at BASE_OFFSET + 8*k; 8-byte aligned.
- BAR_SEL, 0, index into trn_rbar_hit_n that must be active (low).

Ports:
- trn_clk  in  1  core clock.
- trn_reset_n  in  1  asynchronous active-low reset.
- trn_rd  in  64  RX data.
- trn_rrem_n  in  8  RX remainder.
- trn_rsof_n  in  1  start of frame.
- trn_reof_n  in  1  end of frame.
- trn_rsrc_rdy_n  in  1  source ready.
- trn_rsrc_dsc_n  in  1  source discontinue.
- trn_rdst_rdy_n  in  1  destination ready, observed only; a beat is valid when rsrc_rdy_n=0 and rdst_rdy_n=0.
- trn_rbar_hit_n  in  7  BAR hit.
- page_addr_flat  out  64*NUM_PAGES  slot addresses; slot k at [64k+63:64k].
- page_ready  out  NUM_PAGES  slot k holds a valid address owned by hardware.
- cur_page_addr  out  64  address of slot rd_ptr.
- cur_page_idx  out  IDX_W  rd_ptr.
- cur_page_valid  out  1  page_ready[rd_ptr].
- page_done  in  1  one-cycle release of the current page.
- ready_count  out  IDX_W+1  popcount of page_ready.
- overrun_err  out  1  sticky; set when the host writes a slot that is still owned.

Behaviour:
- Reset (async assert, sync release): parser IDLE, page_ready=0, all addresses=0, rd_ptr=0, ready_count=0, overrun_err=0.
- Accepted TLP: beat 0 has rsof and a BAR_SEL hit; fmt/type is 7'b10_00000 (MWr 3DW) or 7'b11_00000 (MWr 4DW); length=2; first BE=4'hF; last BE=4'hF.
- Accepted TLP: the address is in window, 8-byte aligned, and slot index < NUM_PAGES.
- Any other TLP is ignored whole: parser goes to DISCARD until reof.
- Parser states:
  - IDLE: valid beat with rsof, header OK -> B1; header bad -> DISCARD unless reof is on the same beat.
  - B1 (3DW): address=trn_rd[63:32], DW0=trn_rd[31:0] -> B2.
  - B1 (4DW): address=trn_rd[31:0]; upper address is ignored -> B2.
  - B2 (3DW): DW1=trn_rd[63:32]; must carry reof -> commit, IDLE.
  - B2 (4DW): DW0=trn_rd[63:32], DW1=trn_rd[31:0]; must carry reof -> commit, IDLE.
  - DISCARD: wait for a valid beat with reof -> IDLE.
- Invalid beats (rsrc_rdy_n=1) hold the parser state.
- trn_rsrc_dsc_n=0 in any state -> IDLE, no commit.
- A reof earlier than B2 aborts the TLP with no commit.
- Byte order: each data DW is byte-swapped.
  - Slot address = {bswap(DW1), bswap(DW0)}.
  - Bits [11:0] are forced to 0.
- Commit happens on the edge sampling the final beat:
  - Writes address[k] and sets page_ready[k].
  - Visible the following cycle, so latency from the final beat is 1 cycle.
- Overrun: commit to slot k while page_ready[k]=1 and k is not being released this cycle:
  - Write dropped, address unchanged.
  - overrun_err set.
- Release: page_done=1 with cur_page_valid=1 clears page_ready[rd_ptr] and advances rd_ptr mod NUM_PAGES (wraps NUM_PAGES-1 -> 0).
- page_done with cur_page_valid=0 is ignored: no pointer move, no error.
- Simultaneous release of slot k and commit to slot k: release then commit.
  - Slot ends ready with the new address.
  - No overrun; rd_ptr still advances.
- ready_count is registered and consistent with page_ready every cycle; a commit and a release in the same cycle leave it unchanged.
- cur_page_* is a combinational mux off registers.

Decomposition:
- Shared package pcie_tlp_pkg:
  - fmt/type constants MWR32_FMT_TYPE and MWR64_FMT_TYPE.
  - Header field bit positions: length, first BE, last BE.
  - bswap32 function.
- One natural sub-module, tlp_mwr_2dw_parser:
  - Contains the IDLE/B1/B2/DISCARD FSM.
  - Outputs commit pulse, slot index and 64-bit data.
  - Reusable by the MDIO host-interface successor.
- The ring registers, pointer and error logic stay in the top.

Test Plan:
- 3DW MWr, length 2, BAR0, offset 0x048, data DWs 0x00100000_00000000 raw (bytes reversed) -> page_ready=4'b0010; page_addr slot1=64'h0000_0000_0000_1000; latency 1 cycle after reof.
- Fill slots 0..3 with 4DW writes, then pulse page_done four times -> cur_page_idx 0,1,2,3,0; ready_count 4,3,2,1,0; cur_page_valid=0 at the end.
- Write slot 0 while ready, then a 2nd write to slot 0 -> overrun_err=1, slot 0 keeps the first address; a same-cycle page_done on slot 0 plus commit -> no error, new address, rd_ptr=1.
- Discontinue asserted on B2, length=1 TLP, BAR1 hit, MRd type, offset 0x044 -> no page_ready change, parser returns to IDLE, next valid write commits.
- Invalid beats inserted between every beat (rsrc_rdy_n toggling) -> identical result to back-to-back.
- Reset asserted mid-TLP -> all outputs 0 immediately; trailing beats until reof do not commit.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - shared PCIe TLP constants, beat-0 field positions and byte swap
package pcie_tlp_pkg;

  localparam logic [6:0] MWR32_FMT_TYPE = 7'b10_00000;
  localparam logic [6:0] MWR64_FMT_TYPE = 7'b11_00000;

  // Field LSBs within TRN beat 0: header DW0 in [63:32], DW1 in [31:0]
  localparam int FMT_TYPE_LSB = 56;
  localparam int LEN_LSB      = 32;
  localparam int LAST_BE_LSB  = 4;
  localparam int FIRST_BE_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_B1,
    S_B2,
    S_DISCARD
  } mwr_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/rx_huge_pages_ring_if.sv
// rtl/rx_huge_pages_ring_if.sv - TRN RX local-link bundle
interface rx_huge_pages_ring_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n;

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
    output trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n, trn_rbar_hit_n
  );

  modport slave (
    input trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
    input trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n, trn_rbar_hit_n
  );
endinterface

// File: rtl/tlp_mwr_2dw_parser.sv
// rtl/tlp_mwr_2dw_parser.sv - parses 2-DW memory writes into an indexed 64-bit slot window
module tlp_mwr_2dw_parser
  import pcie_tlp_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter int          IDX_W       = 2,
  parameter logic [11:0] BASE_OFFSET = 12'h040,
  parameter int          BAR_SEL     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rx_huge_pages_ring_if.slave  rx,
  output logic                 commit,
  output logic [IDX_W-1:0]     slot,
  output logic [63:0]          data
);

  mwr_state_e       state_q, state_d;
  logic             is_4dw_q, is_4dw_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic [31:0]      dw0_q, dw0_d;

  logic        beat, sof, eof, hdr_ok, addr_ok;
  logic [6:0]  fmt_type;
  logic [31:0] b1_addr, raw_dw0, raw_dw1;
  logic [11:0] off;
  logic        unused_bits;

  assign beat     = !rx.trn_rsrc_rdy_n && !rx.trn_rdst_rdy_n;
  assign sof      = !rx.trn_rsof_n;
  assign eof      = !rx.trn_reof_n;
  assign fmt_type = rx.trn_rd[FMT_TYPE_LSB +: 7];
  assign hdr_ok   = !rx.trn_rbar_hit_n[BAR_SEL]
                  && (fmt_type == MWR32_FMT_TYPE || fmt_type == MWR64_FMT_TYPE)
                  && rx.trn_rd[LEN_LSB +: 10] == 10'd2
                  && rx.trn_rd[FIRST_BE_LSB +: 4] == 4'hF
                  && rx.trn_rd[LAST_BE_LSB +: 4] == 4'hF;

  // Only the BAR-relative low 12 bits select a slot; upper address bits are don't-care
  assign b1_addr = is_4dw_q ? rx.trn_rd[31:0] : rx.trn_rd[63:32];
  assign off     = b1_addr[11:0] - BASE_OFFSET;
  assign addr_ok = (b1_addr[11:0] >= BASE_OFFSET) && (b1_addr[2:0] == 3'b000)
                && (off[11:3] < 9'(NUM_SLOTS));

  assign raw_dw0 = is_4dw_q ? rx.trn_rd[63:32] : dw0_q;
  assign raw_dw1 = is_4dw_q ? rx.trn_rd[31:0]  : rx.trn_rd[63:32];
  assign data    = {bswap32(raw_dw1), bswap32(raw_dw0)} & ~64'hFFF;
  assign slot    = slot_q;

  assign unused_bits = ^{b1_addr[31:12], off[2:0], rx.trn_rrem_n};

  always_comb begin
    state_d  = state_q;
    is_4dw_d = is_4dw_q;
    slot_d   = slot_q;
    dw0_d    = dw0_q;
    commit   = 1'b0;
    if (!rx.trn_rsrc_dsc_n) begin
      state_d = S_IDLE;
    end else if (beat) begin
      case (state_q)
        S_IDLE: begin
          if (sof) begin
            if (eof) begin
              state_d = S_IDLE;
            end else if (hdr_ok) begin
              state_d  = S_B1;
              is_4dw_d = fmt_type[5];
            end else begin
              state_d = S_DISCARD;
            end
          end
        end
        S_B1: begin
          if (eof) begin
            state_d = S_IDLE;
          end else if (addr_ok) begin
            state_d = S_B2;
            slot_d  = off[IDX_W+2:3];
            dw0_d   = rx.trn_rd[31:0];
          end else begin
            state_d = S_DISCARD;
          end
        end
        S_B2: begin
          state_d = eof ? S_IDLE : S_DISCARD;
          commit  = eof;
        end
        S_DISCARD: begin
          if (eof) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_4dw_q <= 1'b0;
      slot_q   <= '0;
      dw0_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_4dw_q <= is_4dw_d;
      slot_q   <= slot_d;
      dw0_q    <= dw0_d;
    end
  end

endmodule

// File: rtl/rx_huge_pages_ring.sv
// rtl/rx_huge_pages_ring.sv - ring of host huge-page base addresses posted through BAR0 writes
module rx_huge_pages_ring
  import pcie_tlp_pkg::*;
#(
  parameter int          NUM_PAGES   = 4,
  parameter int          IDX_W       = 2,
  parameter logic [11:0] BASE_OFFSET = 12'h040,
  parameter int          BAR_SEL     = 0
) (
  input  logic                      trn_clk,
  input  logic                      trn_reset_n,
  rx_huge_pages_ring_if.slave       rx,
  output logic [64*NUM_PAGES-1:0]   page_addr_flat,
  output logic [NUM_PAGES-1:0]      page_ready,
  output logic [63:0]               cur_page_addr,
  output logic [IDX_W-1:0]          cur_page_idx,
  output logic                      cur_page_valid,
  input  logic                      page_done,
  output logic [IDX_W:0]            ready_count,
  output logic                      overrun_err
);

  logic [63:0]          addr_q [NUM_PAGES];
  logic [NUM_PAGES-1:0] ready_q, ready_rel;
  logic [IDX_W-1:0]     rd_ptr_q;
  logic [IDX_W:0]       count_q;
  logic                 overrun_q;

  logic             commit, commit_ok, rel;
  logic [IDX_W-1:0] slot;
  logic [63:0]      data;

  tlp_mwr_2dw_parser #(
    .NUM_SLOTS   (NUM_PAGES),
    .IDX_W       (IDX_W),
    .BASE_OFFSET (BASE_OFFSET),
    .BAR_SEL     (BAR_SEL)
  ) u_parser (
    .clk    (trn_clk),
    .rst_n  (trn_reset_n),
    .rx     (rx),
    .commit (commit),
    .slot   (slot),
    .data   (data)
  );

  assign cur_page_valid = ready_q[rd_ptr_q];
  assign rel            = page_done && cur_page_valid;

  // Release is applied before the commit check, so a slot freed this cycle can be refilled at once
  always_comb begin
    ready_rel = ready_q;
    if (rel) ready_rel[rd_ptr_q] = 1'b0;
  end

  assign commit_ok = commit && !ready_rel[slot];

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      for (int k = 0; k < NUM_PAGES; k++) addr_q[k] <= '0;
      ready_q   <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rel) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (commit_ok) addr_q[slot] <= data;
      if (commit && ready_rel[slot]) overrun_q <= 1'b1;
      ready_q <= ready_rel | (commit_ok ? (NUM_PAGES'(1) << slot) : '0);
      if (commit_ok && !rel) count_q <= count_q + 1'b1;
      else if (rel && !commit_ok) count_q <= count_q - 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_PAGES; k++) begin : g_flat
    assign page_addr_flat[64*k +: 64] = addr_q[k];
  end

  assign page_ready    = ready_q;
  assign cur_page_addr = addr_q[rd_ptr_q];
  assign cur_page_idx  = rd_ptr_q;
  assign ready_count   = count_q;
  assign overrun_err   = overrun_q;

endmodule
